// File: rtl/frame_stim_gen.sv
// frame_stim_gen
//   Run-time configurable frame source for the transmit path. Emits a run of
//   frames (header of zeros, body of fill+frame_idx, trailer of all-ones)
//   separated by a programmable idle gap, with per-frame priority, and counts
//   discard strobes coming back from the transmit path.
// Ports
//   clk_sys, reset            clock, synchronous active-high reset
//   start, stop               run control pulses
//   cfg_*                     run configuration, captured on an accepted start
//   m_discard_en              discard strobe, counted into `discards`
//   f_data_in .. f_hi_priority  registered frame beat outputs
//   busy, done                run status
//   frames_sent, discards     saturating per-run counters
module frame_stim_gen #(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 12,
  parameter int CNT_W     = 16,
  parameter int HDR_BYTES = 4,
  parameter int TRL_BYTES = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   cfg_num_frames,
  input  logic [LEN_W-1:0]   cfg_frame_len,
  input  logic [7:0]         cfg_gap,
  input  logic [1:0]         cfg_prio_mode,
  input  logic [DATA_W-1:0]  cfg_fill,
  input  logic               m_discard_en,
  output logic [DATA_W-1:0]  f_data_in,
  output logic               f_rec_data_valid,
  output logic               f_rec_frame_valid,
  output logic [2*LEN_W-1:0] f_ctrl_in,
  output logic               f_hi_priority,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frames_sent,
  output logic [CNT_W-1:0]   discards
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_BODY = 3'd2;
  localparam logic [2:0] S_TRL  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(HDR_BYTES + TRL_BYTES + 1);
  localparam logic [LEN_W-1:0] OVERHEAD = LEN_W'(HDR_BYTES + TRL_BYTES);
  localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(HDR_BYTES - 1);
  localparam logic [LEN_W-1:0] TRL_LAST = LEN_W'(TRL_BYTES - 1);
  localparam logic [7:0]       SEED     = 8'hA5;

  // FSM / sequencing state
  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             stop_pend_q, stop_pend_d;

  // configuration captured at start
  logic [CNT_W-1:0]  num_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        gap_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;

  // registered outputs
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dv_q, fv_q, prio_q, busy_q, done_q;
  logic [2*LEN_W-1:0] ctrl_q;
  logic [CNT_W-1:0]   frames_q, frames_d, disc_q, disc_d;

  logic             start_acc, in_frame, run_state, frame_end, prio_sel, fv_d;
  logic [CNT_W-1:0] fidx_nxt;
  logic [LEN_W-1:0] body_last, gap_last;
  logic [7:0]       lfsr_nxt;

  assign start_acc = (state_q == S_IDLE) && start;
  assign in_frame  = (state_q == S_HDR) || (state_q == S_BODY) || (state_q == S_TRL);
  assign run_state = in_frame || (state_q == S_GAP);
  assign fidx_nxt  = fidx_q + CNT_W'(1);
  assign body_last = len_q - OVERHEAD - LEN_W'(1);
  assign gap_last  = LEN_W'(gap_q) - LEN_W'(1);
  // Fibonacci LFSR, taps 8,6,5,4
  assign lfsr_nxt  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    fidx_d      = fidx_q;
    lfsr_d      = lfsr_q;
    stop_pend_d = stop_pend_q;
    frame_end   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        beat_d      = '0;
        fidx_d      = '0;
        lfsr_d      = SEED;
        stop_pend_d = 1'b0;
        state_d     = (cfg_num_frames == '0) ? S_DONE : S_HDR;
      end
      S_HDR: begin
        stop_pend_d = stop_pend_q | stop;
        if (beat_q == HDR_LAST) begin beat_d = '0; state_d = S_BODY; end
        else beat_d = beat_q + LEN_W'(1);
      end
      S_BODY: begin
        stop_pend_d = stop_pend_q | stop;
        if (beat_q == body_last) begin beat_d = '0; state_d = S_TRL; end
        else beat_d = beat_q + LEN_W'(1);
      end
      S_TRL: begin
        stop_pend_d = stop_pend_q | stop;
        if (beat_q == TRL_LAST) begin
          frame_end = 1'b1;
          beat_d    = '0;
          fidx_d    = fidx_nxt;
          lfsr_d    = lfsr_nxt;
          // a stop seen anywhere in this frame ends the run here, no gap
          if (fidx_nxt == num_q || stop || stop_pend_q) state_d = S_DONE;
          else if (gap_q == '0)                         state_d = S_HDR;
          else                                          state_d = S_GAP;
        end else beat_d = beat_q + LEN_W'(1);
      end
      S_GAP: begin
        if (stop) begin beat_d = '0; state_d = S_DONE; end
        else if (beat_q == gap_last) begin beat_d = '0; state_d = S_HDR; end
        else beat_d = beat_q + LEN_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (mode_q)
      2'b00:   prio_sel = 1'b0;
      2'b01:   prio_sel = 1'b1;
      2'b10:   prio_sel = ~fidx_q[0];
      default: prio_sel = lfsr_q[0];
    endcase
  end

  always_comb begin
    data_d = '0;
    case (state_q)
      S_BODY:  data_d = fill_q + DATA_W'(fidx_q);
      S_TRL:   data_d = '1;
      default: data_d = '0;
    endcase
  end

  assign fv_d     = (state_q == S_HDR) && (beat_q == '0);
  assign frames_d = start_acc ? '0 :
                    (frame_end && !(&frames_q)) ? frames_q + CNT_W'(1) : frames_q;
  assign disc_d   = start_acc ? '0 :
                    (m_discard_en && !(&disc_q)) ? disc_q + CNT_W'(1) : disc_q;

  // Outputs are one cycle behind state_q: state_q describes the beat that
  // appears on the outputs after the next edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      fidx_q      <= '0;
      lfsr_q      <= SEED;
      stop_pend_q <= 1'b0;
      num_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      mode_q      <= '0;
      fill_q      <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      fv_q        <= 1'b0;
      ctrl_q      <= '0;
      prio_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frames_q    <= '0;
      disc_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      fidx_q      <= fidx_d;
      lfsr_q      <= lfsr_d;
      stop_pend_q <= stop_pend_d;
      if (start_acc) begin
        num_q  <= cfg_num_frames;
        len_q  <= (cfg_frame_len < MIN_LEN) ? MIN_LEN : cfg_frame_len;
        gap_q  <= cfg_gap;
        mode_q <= cfg_prio_mode;
        fill_q <= cfg_fill;
      end
      data_q   <= data_d;
      dv_q     <= in_frame;
      fv_q     <= fv_d;
      ctrl_q   <= fv_d ? {len_q, len_q} : '0;
      prio_q   <= in_frame ? prio_sel : 1'b0;
      busy_q   <= run_state;
      done_q   <= (state_q == S_DONE);
      frames_q <= frames_d;
      disc_q   <= disc_d;
    end
  end

  assign f_data_in         = data_q;
  assign f_rec_data_valid  = dv_q;
  assign f_rec_frame_valid = fv_q;
  assign f_ctrl_in         = ctrl_q;
  assign f_hi_priority     = prio_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign frames_sent       = frames_q;
  assign discards          = disc_q;
endmodule

// File: tb/tb_frame_stim_gen.sv
module tb_frame_stim_gen;
  localparam int DW = 8;
  localparam int LW = 12;
  localparam int CW = 16;

  logic          clk_sys = 1'b0;
  logic          reset, start, stop, m_discard_en;
  logic [CW-1:0] cfg_num_frames;
  logic [LW-1:0] cfg_frame_len;
  logic [7:0]    cfg_gap;
  logic [1:0]    cfg_prio_mode;
  logic [DW-1:0] cfg_fill;
  logic [DW-1:0] f_data_in;
  logic          f_rec_data_valid, f_rec_frame_valid, f_hi_priority, busy, done;
  logic [2*LW-1:0] f_ctrl_in;
  logic [CW-1:0] frames_sent, discards;

  frame_stim_gen dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .stop(stop),
    .cfg_num_frames(cfg_num_frames), .cfg_frame_len(cfg_frame_len), .cfg_gap(cfg_gap),
    .cfg_prio_mode(cfg_prio_mode), .cfg_fill(cfg_fill), .m_discard_en(m_discard_en),
    .f_data_in(f_data_in), .f_rec_data_valid(f_rec_data_valid),
    .f_rec_frame_valid(f_rec_frame_valid), .f_ctrl_in(f_ctrl_in),
    .f_hi_priority(f_hi_priority), .busy(busy), .done(done),
    .frames_sent(frames_sent), .discards(discards)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          dv;
    logic          fv;
    logic          prio;
    logic [7:0]    data;
    logic [23:0]   ctrl;
  } obs_t;

  obs_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic obs_t observe();
    obs_t o;
    o.busy = busy;             o.done = done;
    o.dv   = f_rec_data_valid; o.fv   = f_rec_frame_valid;
    o.prio = f_hi_priority;    o.data = f_data_in;
    o.ctrl = f_ctrl_in;
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle output stream of one run, starting with the first
  // cycle after the start edge's successor; stop_at is the loop index after
  // which stop is pulsed (-1: none).
  task automatic build(input int num, input int len, input int gap, input int mode,
                       input int fill, input int stop_at, output int nframes);
    int le, t, sbt;
    logic [7:0] lf;
    bit pend, endnow;
    obs_t r;
    le = (len < 9) ? 9 : len;
    lf = 8'hA5; t = 0; pend = 0; endnow = 0; nframes = 0;
    sbt = (stop_at >= 0) ? stop_at + 1 : -1;
    for (int f = 0; f < num; f++) begin
      for (int b = 0; b < le; b++) begin
        if (t == sbt) pend = 1;
        r = '0; r.busy = 1'b1; r.dv = 1'b1;
        r.prio = (mode == 1) || (mode == 2 && (f % 2) == 0) || (mode == 3 && lf[0]);
        if (b == 0) begin r.fv = 1'b1; r.ctrl = {LW'(le), LW'(le)}; end
        if (b >= 4 && b < le - 4) r.data = 8'(fill + f);
        else if (b >= le - 4)     r.data = 8'hFF;
        sb.push_back(r);
        t++;
      end
      nframes++;
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      if (f == num - 1 || pend) break;
      for (int g = 0; g < gap; g++) begin
        r = '0; r.busy = 1'b1;
        sb.push_back(r);
        if (t == sbt) begin endnow = 1; t++; break; end
        t++;
      end
      if (endnow) break;
    end
    r = '0; r.done = 1'b1; sb.push_back(r);
    r = '0;               sb.push_back(r);
  endtask

  task automatic run(input string tag, input int num, input int len, input int gap,
                     input int mode, input int fill, input int stop_at, input int start_at);
    int nf, t;
    obs_t e;
    build(num, len, gap, mode, fill, stop_at, nf);
    cfg_num_frames = CW'(num); cfg_frame_len = LW'(len); cfg_gap = 8'(gap);
    cfg_prio_mode = 2'(mode); cfg_fill = 8'(fill);
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    // config changes after start must not affect this run
    cfg_num_frames = 16'd7; cfg_frame_len = 12'd100; cfg_gap = 8'd0;
    cfg_prio_mode = 2'b00; cfg_fill = 8'h5A;
    t = 0;
    while (sb.size() > 0) begin
      @(posedge clk_sys); #1;
      e = sb.pop_front();
      check($sformatf("%s beat%0d", tag, t), 64'(observe()), 64'(e));
      stop  = (t == stop_at);
      start = (t == start_at);
      t++;
    end
    stop = 1'b0; start = 1'b0;
    check({tag, " frames_sent"}, 64'(frames_sent), 64'(nf));
    check({tag, " discards"},    64'(discards),    64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; m_discard_en = 1'b0;
    cfg_num_frames = '0; cfg_frame_len = '0; cfg_gap = '0; cfg_prio_mode = '0; cfg_fill = '0;
    @(posedge clk_sys); #1;
    check("reset outputs", 64'(observe()), 64'd0);
    check("reset frames",  64'(frames_sent), 64'd0);
    check("reset discards", 64'(discards), 64'd0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // single 512-beat high-priority frame
    run("T1", 1, 512, 0, 1, 8'h00, -1, -1);
    // three alternating-priority frames with a 2-beat gap
    run("T2", 3, 16, 2, 2, 8'h10, -1, -1);
    // short length clamps to 9
    run("T3", 1, 5, 0, 0, 8'h77, -1, -1);
    // stop in beat 20 of the second frame, start mid-run ignored
    run("T4", 10, 32, 3, 2, 8'h20, 54, 10);
    // stop during the gap ends the run immediately
    run("GAPSTOP", 5, 10, 4, 0, 8'h01, 10, -1);
    // back-to-back frames, LFSR priority, body byte wraps
    run("B2B", 2, 9, 0, 3, 8'hFF, -1, -1);
    // empty run
    run("T5", 0, 20, 1, 1, 8'h33, -1, -1);

    for (int i = 0; i < 5; i++) begin
      m_discard_en = 1'b1;
      @(posedge clk_sys); #1;
    end
    m_discard_en = 1'b0;
    @(posedge clk_sys); #1;
    check("T5 discards", 64'(discards), 64'd5);

    // reset mid-body
    cfg_num_frames = 16'd1; cfg_frame_len = 12'd512; cfg_gap = 8'd0;
    cfg_prio_mode = 2'b01; cfg_fill = 8'h00;
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    repeat (100) begin @(posedge clk_sys); #1; end
    check("T6 midrun valid", 64'(f_rec_data_valid), 64'd1);
    check("T6 midrun discards cleared", 64'(discards), 64'd0);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("T6 reset outputs", 64'(observe()), 64'd0);
    check("T6 reset frames",  64'(frames_sent), 64'd0);
    reset = 1'b0;
    @(posedge clk_sys); #1;
    run("T6 rerun", 1, 512, 0, 1, 8'h00, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
